// File: rtl/spectrum_vga_renderer.sv
// rtl/spectrum_vga_renderer.sv - VGA bar-graph renderer for the adapted spectrum buffer
// Counters -> flag/data register -> output register; one 10-bit bin per column.
module spectrum_vga_renderer #(
  parameter int CLK_DIV  = 2,
  parameter int X_OFFSET = 64,
  parameter int N_BINS   = 512,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adaptation_done_i,
  input  logic [15:0] adapt_buff_q_i,
  output logic [9:0]  read_adapt_buff_addr_o,
  output logic        frame_start_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        vga_blank_n_o,
  output logic [7:0]  vga_r_o,
  output logic [7:0]  vga_g_o,
  output logic [7:0]  vga_b_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BIN_BEG    = HW'(X_OFFSET);
  localparam logic [HW-1:0] BIN_END    = HW'(X_OFFSET + N_BINS);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_BASE     = VW'(V_ACTIVE - 1);
  localparam logic [9:0]    HT_MAX     = 10'(V_ACTIVE - 1);
  localparam logic [23:0]   WHITE      = 24'hFFFFFF;
  localparam logic [23:0]   GREEN      = 24'h00FF00;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pending_q, pending_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_start_q;
  logic          ce, frame_evt;

  logic h_act0, v_act0, hs0, vs0, in_bin0;

  logic          act1_q, hs1_q, vs1_q, in_bin1_q;
  logic [VW-1:0] vcnt1_q;
  logic [8:0]    bin1_q;

  logic        hs2_q, vs2_q, blank_n2_q;
  logic [23:0] rgb_q, rgb_d;
  logic [9:0]  height, thresh;

  logic unused_q_bits;
  assign unused_q_bits = ^{adapt_buff_q_i[15:10], adapt_buff_q_i[0]};

  assign ce        = (div_q == DIV_LAST);
  // Counters are about to step from the last active line into vertical blank.
  assign frame_evt = ce && (hcnt_q == H_LAST) && (vcnt_q == V_BASE);

  assign h_act0   = (hcnt_q < H_ACT_END);
  assign v_act0   = (vcnt_q < V_ACT_END);
  assign hs0      = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
  assign vs0      = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
  assign in_bin0  = (hcnt_q >= BIN_BEG) && (hcnt_q < BIN_END);

  assign read_adapt_buff_addr_o = in_bin0 ? 10'(hcnt_q - BIN_BEG) : 10'd0;

  always_comb begin
    div_d        = ce ? '0 : div_q + 1'b1;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    pending_d    = pending_q | adaptation_done_i;
    data_valid_d = data_valid_q;
    if (ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    if (frame_evt) begin
      data_valid_d = data_valid_q | pending_q | adaptation_done_i;
      pending_d    = 1'b0;
    end
  end

  // Bar is lit when its clamped height reaches above this row, measured up from the baseline.
  always_comb begin
    height = ({1'b0, bin1_q} > HT_MAX) ? HT_MAX : {1'b0, bin1_q};
    thresh = HT_MAX - 10'(vcnt1_q);
    rgb_d  = '0;
    if (act1_q && in_bin1_q) begin
      if (vcnt1_q == V_BASE) begin
        rgb_d = WHITE;
      end else if (data_valid_q && (height > thresh)) begin
        rgb_d = GREEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pending_q     <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      in_bin1_q     <= 1'b0;
      vcnt1_q       <= '0;
      bin1_q        <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      blank_n2_q    <= 1'b0;
      rgb_q         <= '0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pending_q     <= pending_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_evt;
      if (ce) begin
        act1_q     <= h_act0 && v_act0;
        hs1_q      <= hs0;
        vs1_q      <= vs0;
        in_bin1_q  <= in_bin0;
        vcnt1_q    <= vcnt_q;
        bin1_q     <= adapt_buff_q_i[9:1];
        hs2_q      <= hs1_q;
        vs2_q      <= vs1_q;
        blank_n2_q <= act1_q;
        rgb_q      <= rgb_d;
      end
    end
  end

  assign frame_start_o = frame_start_q;
  assign vga_hs_o      = hs2_q;
  assign vga_vs_o      = vs2_q;
  assign vga_blank_n_o = blank_n2_q;
  assign vga_r_o       = rgb_q[23:16];
  assign vga_g_o       = rgb_q[15:8];
  assign vga_b_o       = rgb_q[7:0];

endmodule

// File: tb/tb_spectrum_vga_renderer.sv
// tb/tb_spectrum_vga_renderer.sv - scoreboard bench for spectrum_vga_renderer
// Reduced raster geometry keeps several whole frames short.
module tb_spectrum_vga_renderer;

  localparam int CD  = 2;
  localparam int XO  = 4;
  localparam int NB  = 32;
  localparam int HA  = 40, HFP = 4, HSY = 8, HBP = 6;
  localparam int VA  = 24, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FR  = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adone = 1'b0;
  logic [15:0] ram_q = 16'd0;
  logic [9:0]  addr;
  logic        fs, hs, vs, bn;
  logic [7:0]  r, g, b;

  logic [15:0] mem [0:1023];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  typedef struct { int tick; logic [9:0] addr; logic fs; } ctr_t;
  typedef struct { int tick; logic hs; logic vs; logic bn; logic [23:0] rgb; } pix_t;
  ctr_t ctr_q[$];
  pix_t pix_q[$];

  spectrum_vga_renderer #(
    .CLK_DIV(CD), .X_OFFSET(XO), .N_BINS(NB),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .adaptation_done_i(adone),
    .adapt_buff_q_i(ram_q),
    .read_adapt_buff_addr_o(addr),
    .frame_start_o(fs),
    .vga_hs_o(hs),
    .vga_vs_o(vs),
    .vga_blank_n_o(bn),
    .vga_r_o(r),
    .vga_g_o(g),
    .vga_b_o(b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[addr];

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string nm, input int tick, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d got=%h want=%h", nm, tick, act, exp);
    end
  endtask

  // Reference: what the screen should show at raster tick k, straight from the region rules.
  function automatic pix_t model_pix(input int k, input bit dv);
    pix_t p;
    int h, v, ht;
    logic [15:0] w;
    h = k % HT;
    v = (k / HT) % VT;
    p.tick = k;
    p.hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
    p.vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
    p.bn   = (h < HA) && (v < VA);
    p.rgb  = 24'd0;
    if (p.bn && h >= XO && h < XO + NB) begin
      w  = mem[10'(h - XO)];
      ht = int'(w[9:1]);
      if (ht > VA - 1) ht = VA - 1;
      if (v == VA - 1)             p.rgb = 24'hFFFFFF;
      else if (dv && ht + v >= VA) p.rgb = 24'h00FF00;
    end
    return p;
  endfunction

  task automatic push_frame(input int f, input bit dv);
    ctr_t c;
    int k, h, v;
    for (int t = 0; t < FR; t++) begin
      k = f * FR + t;
      h = k % HT;
      v = (k / HT) % VT;
      c.tick = k;
      c.addr = (h >= XO && h < XO + NB) ? 10'(h - XO) : 10'd0;
      c.fs   = (h == 0) && (v == VA);
      ctr_q.push_back(c);
      pix_q.push_back(model_pix(k, dv));
    end
  endtask

  always @(negedge clk) begin : monitor
    int k;
    ctr_t c;
    pix_t p;
    if (mon_en && cyc >= 1) begin
      k = cyc / CD;
      if (cyc % CD == 0) begin
        if (ctr_q.size() == 0) check("ctr_underflow", k, 32'd0, 32'd1);
        else begin
          check("addr", k, 32'(addr), 32'(ctr_q[0].addr));
          check("frame_start", k, 32'(fs), 32'(ctr_q[0].fs));
        end
      end else if (cyc % CD == CD - 1) begin
        if (ctr_q.size() == 0) check("ctr_underflow", k, 32'd0, 32'd1);
        else begin
          c = ctr_q.pop_front();
          check("addr_hold", c.tick, 32'(addr), 32'(c.addr));
          check("frame_start_width", c.tick, 32'(fs), 32'd0);
        end
      end
      if (cyc < 2 * CD) begin
        check("pipe_blank", cyc, 32'({hs, vs, bn, r, g, b}), 32'({1'b1, 1'b1, 1'b0, 24'd0}));
      end else if (cyc % CD == 0) begin
        if (pix_q.size() == 0) check("pix_underflow", k - 2, 32'd0, 32'd1);
        else begin
          p = pix_q.pop_front();
          check("pixel", p.tick, 32'({hs, vs, bn, r, g, b}), 32'({p.hs, p.vs, p.bn, p.rgb}));
        end
      end
    end
  end

  task automatic at_edge(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  task automatic pulse_at(input int n);
    at_edge(n);
    adone = 1'b1;
    @(negedge clk);
    adone = 1'b0;
  endtask

  task automatic randomize_bins();
    logic [15:0] val;
    for (int i = 0; i < NB; i++) begin
      val = 16'($urandom);
      if ($urandom_range(0, 3) != 0) val[9:0] = 10'($urandom_range(0, 2 * VA + 6));
      mem[i] = val;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    ctr_q.delete();
    pix_q.delete();
    adone = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_out", i, 32'({hs, vs, bn, r, g, b, fs}), 32'({1'b1, 1'b1, 1'b0, 24'd0, 1'b0}));
      check("reset_addr", i, 32'(addr), 32'd0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // mode 0: two collapsed mid-frame pulses then directed bins; mode 1: pulse coincident with frame start.
  task automatic run(input int nfr, input int mode);
    bit dv, pend;
    int base, e_edge, rsel;
    dv   = 1'b0;
    pend = 1'b0;
    do_reset();
    for (int f = 0; f < nfr; f++) begin
      base   = CD * f * FR;
      e_edge = CD * (f * FR + VA * HT);
      rsel   = 0;
      push_frame(f, dv);
      if (f == 0 && mode == 0) begin
        pulse_at(base + CD * (5 * HT + 10));
        pulse_at(base + CD * (9 * HT + 3));
        pend = 1'b1;
      end else if (f == 0) begin
        pulse_at(e_edge);
        pend = 1'b1;
      end else begin
        rsel = $urandom_range(0, 3);
        if (rsel == 1) begin
          pulse_at($urandom_range(base + 2, e_edge - 3));
          pend = 1'b1;
        end else if (rsel == 2) begin
          pulse_at(e_edge);
          pend = 1'b1;
        end
      end
      at_edge(e_edge + 1);
      if (pend) begin
        dv   = 1'b1;
        pend = 1'b0;
      end
      randomize_bins();
      if (f == 0 && mode == 0) begin
        mem[0]  = {6'h2a, 10'd1023};
        mem[1]  = {6'h3f, 10'd1};
        mem[10] = {6'h00, 10'd30};
      end
      if (rsel == 3) begin
        pulse_at($urandom_range(e_edge + 3, base + CD * FR - 4));
        pend = 1'b1;
      end
    end
    push_frame(nfr, dv);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    run(5, 0);
    at_edge(CD * (5 * FR + (VA / 2) * HT + 20));
    run(3, 1);
    at_edge(CD * (3 * FR + 3 * HT));
    mon_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
